// File: rtl/mandelbrot_pixel_writer.sv
// Mandelbrot result sink: buffers finished pixels, maps iteration counts to RGB332
// and writes them to the framebuffer SRAM. Optional bounds clipping: PIXEL_WRITER_CLIP_EN.
module mandelbrot_pixel_writer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] max_iter,
  input  logic        fin_val,
  input  logic [10:0] single_num_iter,
  input  logic [9:0]  single_x,
  input  logic [9:0]  single_y,
  output logic        result_ready,
  output logic [18:0] sram_address,
  output logic [7:0]  sram_writedata,
  output logic        sram_write,
  input  logic        sram_waitrequest,
  output logic [18:0] pixels_written,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam logic [18:0] FRAME_LAST = 19'(H_RES * V_RES - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  logic [9:0]       fifo_x [FIFO_DEPTH];
  logic [9:0]       fifo_y [FIFO_DEPTH];
  logic [10:0]      fifo_n [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             commit;
  logic             skip;
  logic [9:0]       head_x;
  logic [9:0]       head_y;
  logic [31:0]      head_n;
  logic [18:0]      head_addr;
  logic [7:0]       colour;
  state_t           state;

  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign result_ready = !fifo_full;
  assign push         = fin_val && result_ready;
  assign head_x       = fifo_x[rd_ptr];
  assign head_y       = fifo_y[rd_ptr];
  assign head_n       = 32'(fifo_n[rd_ptr]);
  assign commit       = (state == WRITE) && !sram_waitrequest;

`ifdef PIXEL_WRITER_CLIP_EN
  // Off-screen heads are dropped in IDLE but still counted to keep frame alignment.
  assign skip = (state == IDLE) && !fifo_empty &&
                ((32'(head_x) >= H_RES) || (32'(head_y) >= V_RES));
`else
  assign skip = 1'b0;
`endif

  assign pop = commit || skip;

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x[wr_ptr] <= single_x;
      fifo_y[wr_ptr] <= single_y;
      fifo_n[wr_ptr] <= single_num_iter;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Colour bands from the head's iteration count; max_iter=0 lands in the first band.
  always_comb begin
    colour = 8'h03;
    if (head_n >= max_iter)              colour = 8'h00;
    else if (head_n >= (max_iter >> 3))  colour = 8'hE0;
    else if (head_n >= (max_iter >> 4))  colour = 8'hEC;
    else if (head_n >= (max_iter >> 5))  colour = 8'h1C;
    else if (head_n >= (max_iter >> 6))  colour = 8'h1F;
  end

  if (H_RES == 640) begin : g_addr_shift
    assign head_addr = (19'(head_y) << 9) + (19'(head_y) << 7) + 19'(head_x);
  end else begin : g_addr_mul
    assign head_addr = 19'(19'(head_y) * 19'(H_RES)) + 19'(head_x);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      sram_write     <= 1'b0;
      sram_address   <= '0;
      sram_writedata <= '0;
      pixels_written <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fin_val && !result_ready) overflow <= 1'b1;
      if (pop) begin
        if (pixels_written == FRAME_LAST) begin
          pixels_written <= '0;
          frame_done     <= 1'b1;
        end else begin
          pixels_written <= pixels_written + 19'd1;
        end
      end
      case (state)
        IDLE: begin
          if (!fifo_empty && !skip) begin
            sram_address   <= head_addr;
            sram_writedata <= colour;
            sram_write     <= 1'b1;
            state          <= WRITE;
          end
        end
        WRITE: begin
          if (!sram_waitrequest) begin
            sram_write <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_pixel_writer.sv
// Self-checking bench: a full-size writer and a 4x2 writer checked against a queue-based model.
module tb_mandelbrot_pixel_writer;

  localparam int DEPTH = 8;

  typedef struct {
    logic [18:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] max_iter;
  logic        fv  [2];
  logic [10:0] nin [2];
  logic [9:0]  xin [2];
  logic [9:0]  yin [2];
  logic        wt  [2];
  logic        rdy [2];
  logic [18:0] addr[2];
  logic [7:0]  data[2];
  logic        wr  [2];
  logic [18:0] pw  [2];
  logic        fd  [2];
  logic        ov  [2];

  wr_t expq [2][$];
  int  acc[2], com[2], exp_pw[2], fd_seen[2], wr_cycles[2];
  bit  exp_ov[2], exp_fd[2], prev_stall[2];
  int  checks = 0;
  int  errors = 0;
  int  base_acc, base_pw, base_wr;

  always #5 clk = ~clk;

  mandelbrot_pixel_writer u_big (
    .clk(clk), .reset(reset), .max_iter(max_iter), .fin_val(fv[0]),
    .single_num_iter(nin[0]), .single_x(xin[0]), .single_y(yin[0]),
    .result_ready(rdy[0]), .sram_address(addr[0]), .sram_writedata(data[0]),
    .sram_write(wr[0]), .sram_waitrequest(wt[0]), .pixels_written(pw[0]),
    .frame_done(fd[0]), .overflow(ov[0])
  );

  mandelbrot_pixel_writer #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(DEPTH)) u_small (
    .clk(clk), .reset(reset), .max_iter(max_iter), .fin_val(fv[1]),
    .single_num_iter(nin[1]), .single_x(xin[1]), .single_y(yin[1]),
    .result_ready(rdy[1]), .sram_address(addr[1]), .sram_writedata(data[1]),
    .sram_write(wr[1]), .sram_waitrequest(wt[1]), .pixels_written(pw[1]),
    .frame_done(fd[1]), .overflow(ov[1])
  );

  function automatic int unsigned hres(input int i);
    return (i == 0) ? 640 : 4;
  endfunction

  function automatic int unsigned vres(input int i);
    return (i == 0) ? 480 : 2;
  endfunction

  function automatic logic [18:0] ref_addr(input int i, input logic [9:0] xx, input logic [9:0] yy);
    int unsigned v;
    v = int'(yy) * hres(i) + int'(xx);
    return 19'(v % 524288);
  endfunction

  function automatic logic [7:0] ref_colour(input logic [10:0] nn, input logic [31:0] m);
    int unsigned v;
    v = int'(nn);
    if (v >= m)      return 8'h00;
    if (v >= m / 8)  return 8'hE0;
    if (v >= m / 16) return 8'hEC;
    if (v >= m / 32) return 8'h1C;
    if (v >= m / 64) return 8'h1F;
    return 8'h03;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, return 1ns after the rise.
  task automatic cycle();
    wr_t e;
    int  occ;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      occ = acc[i] - com[i];
      chk("result_ready", 32'(rdy[i]), 32'(occ < DEPTH));
      chk("overflow", 32'(ov[i]), 32'(exp_ov[i]));
      chk("pixels_written", 32'(pw[i]), 32'(exp_pw[i]));
      chk("frame_done", 32'(fd[i]), 32'(exp_fd[i]));
      if (fd[i]) fd_seen[i]++;
      exp_fd[i] = 1'b0;
      if (prev_stall[i]) chk("write_held", 32'(wr[i]), 32'd1);
      if (wr[i]) begin
        wr_cycles[i]++;
        if (expq[i].size() == 0) begin
          chk("unexpected_write", 32'(wr[i]), 32'd0);
        end else begin
          e = expq[i][0];
          chk("sram_address", 32'(addr[i]), 32'(e.a));
          chk("sram_writedata", 32'(data[i]), 32'(e.d));
          if (!wt[i]) begin
            void'(expq[i].pop_front());
            com[i]++;
            exp_pw[i] = (exp_pw[i] + 1) % int'(hres(i) * vres(i));
            if (exp_pw[i] == 0) exp_fd[i] = 1'b1;
          end
        end
      end
      prev_stall[i] = wr[i] && wt[i];
      if (fv[i]) begin
        if (occ < DEPTH) begin
          expq[i].push_back('{a: ref_addr(i, xin[i], yin[i]), d: ref_colour(nin[i], max_iter)});
          acc[i]++;
        end else begin
          exp_ov[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fv[i] = 1'b0; wt[i] = 1'b0; xin[i] = '0; yin[i] = '0; nin[i] = '0;
    end
    #1;
    for (int i = 0; i < 2; i++) chk("rst_write_async", 32'(wr[i]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_write", 32'(wr[i]), 32'd0);
      chk("rst_address", 32'(addr[i]), 32'd0);
      chk("rst_data", 32'(data[i]), 32'd0);
      chk("rst_pixels", 32'(pw[i]), 32'd0);
      chk("rst_frame_done", 32'(fd[i]), 32'd0);
      chk("rst_overflow", 32'(ov[i]), 32'd0);
      expq[i].delete();
      acc[i] = 0; com[i] = 0; exp_pw[i] = 0; fd_seen[i] = 0; wr_cycles[i] = 0;
      exp_ov[i] = 1'b0; exp_fd[i] = 1'b0; prev_stall[i] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk("ready_after_reset", 32'(rdy[i]), 32'd1);
  endtask

  task automatic drive(input int i, input logic [9:0] xx, input logic [9:0] yy, input logic [10:0] nn);
    fv[i] = 1'b1; xin[i] = xx; yin[i] = yy; nin[i] = nn;
  endtask

  task automatic drain(input int n);
    fv[0] = 1'b0; fv[1] = 1'b0; wt[0] = 1'b0; wt[1] = 1'b0;
    repeat (n) cycle();
    for (int i = 0; i < 2; i++) chk("drained", 32'(expq[i].size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    max_iter = 32'd1000;
    do_reset();
    repeat (3) cycle();

    // Single pixel latency and address
    drive(0, 10'd5, 10'd2, 11'd1000);
    cycle();
    fv[0] = 1'b0;
    chk("lat_edge1", 32'(wr[0]), 32'd0);
    cycle();
    chk("lat_edge2", 32'(wr[0]), 32'd1);
    chk("single_addr", 32'(addr[0]), 32'd1285);
    chk("single_data", 32'(data[0]), 32'h00);
    cycle();
    chk("single_done", 32'(wr[0]), 32'd0);
    chk("single_count", 32'(pw[0]), 32'd1);
    drain(4);

    // Colour bands, back to back
    max_iter = 32'd1024;
    foreach (nin[k]) nin[k] = '0;
    begin
      logic [10:0] bands [6];
      bands = '{11'd1024, 11'd128, 11'd64, 11'd32, 11'd16, 11'd3};
      for (int k = 0; k < 6; k++) begin
        drive(0, 10'd0, 10'd0, bands[k]);
        cycle();
      end
    end
    drain(20);

    // max_iter of zero maps everything to black
    max_iter = 32'd0;
    drive(0, 10'd1, 10'd1, 11'd0); cycle();
    drive(0, 10'd2, 10'd1, 11'd5); cycle();
    drain(8);
    max_iter = 32'd1024;

    // Waitrequest stall for 5 cycles
    base_pw = exp_pw[0];
    base_wr = wr_cycles[0];
    wt[0] = 1'b1;
    drive(0, 10'd7, 10'd9, 11'd40);
    cycle();
    fv[0] = 1'b0;
    cycle();
    repeat (5) cycle();
    wt[0] = 1'b0;
    cycle();
    cycle();
    chk("stall_cycles", 32'(wr_cycles[0] - base_wr), 32'd6);
    chk("stall_count", 32'(pw[0]), 32'(base_pw + 1));

    // Backpressure: 10 pushes into a stalled sink
    base_acc = acc[0];
    wt[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(0, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 11'($urandom));
      cycle();
    end
    fv[0] = 1'b0;
    cycle();
    chk("bp_overflow", 32'(ov[0]), 32'd1);
    chk("bp_ready", 32'(rdy[0]), 32'd0);
    chk("bp_accepted", 32'(acc[0] - base_acc), 32'd8);
    drain(25);

    // Frame wrap on the 4x2 instance
    for (int k = 0; k < 8; k++) begin
      drive(1, 10'($urandom_range(0, 3)), 10'($urandom_range(0, 1)), 11'($urandom));
      cycle();
    end
    drain(25);
    chk("frame_pulses", 32'(fd_seen[1]), 32'd1);
    chk("frame_wrap_count", 32'(pw[1]), 32'd0);

`ifdef PIXEL_WRITER_CLIP_EN
    drive(1, 10'd4, 10'd0, 11'd7);
    @(posedge clk);
    #1;
    fv[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("clip_no_write", 32'(wr[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    exp_pw[1] = (exp_pw[1] + 1) % 8;
    chk("clip_count", 32'(pw[1]), 32'(exp_pw[1]));
`endif

    // Randomised traffic with random stalls, three max_iter settings
    for (int r = 0; r < 3; r++) begin
      max_iter = 32'($urandom_range(1, 2047));
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < 2; i++) begin
          fv[i]  = ($urandom_range(0, 1) == 1);
          nin[i] = 11'($urandom);
          wt[i]  = ($urandom_range(0, 9) < 3);
`ifdef PIXEL_WRITER_CLIP_EN
          xin[i] = 10'($urandom_range(0, hres(i) - 1));
          yin[i] = 10'($urandom_range(0, vres(i) - 1));
`else
          xin[i] = 10'($urandom);
          yin[i] = 10'($urandom);
`endif
        end
        cycle();
      end
      drain(30);
    end

    // Reset during an in-flight write
    wt[0] = 1'b1;
    drive(0, 10'd3, 10'd3, 11'd9);
    cycle();
    fv[0] = 1'b0;
    cycle();
    chk("midwrite_active", 32'(wr[0]), 32'd1);
    do_reset();
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
